// File: rtl/alarm_blink_decoder_if.sv
// rtl/alarm_blink_decoder_if.sv - blink-line and recovered-alarm signal bundle
// Purpose: groups the blink input and the decoded status outputs of one LED line.
// Signals:
//   L          blink line driven toward the decoder (asynchronous to CLK)
//   A          recovered alarm flag
//   steady_on  line held high past the idle timeout
//   err        one-cycle pulse on an out-of-window half-period
//   half_len   last measured half-period, saturating
// Modports: master drives L and observes status; slave is the decoder.
interface alarm_blink_decoder_if #(
   parameter int CNT_W = 4
);
   logic             L;
   logic             A;
   logic             steady_on;
   logic             err;
   logic [CNT_W-1:0] half_len;

   modport master (
      output L,
      input  A,
      input  steady_on,
      input  err,
      input  half_len
   );

   modport slave (
      input  L,
      output A,
      output steady_on,
      output err,
      output half_len
   );
endinterface

// File: rtl/alarm_blink_decoder.sv
// rtl/alarm_blink_decoder.sv - recovers an alarm flag from one LED blink line
// Purpose: synchronizes the blink line, measures each half-period, qualifies it
//   against [MIN_HALF, MAX_HALF] and asserts A after CONFIRM consecutive good
//   edges. Flags a line stuck high and malformed half-periods.
// Ports:
//   CLK    in   clock, all state on rising edge
//   reset  in   synchronous, active-low
//   bus    slave modport: L in; A, steady_on, err, half_len out (all registered)
module alarm_blink_decoder #(
   parameter int MIN_HALF = 2,
   parameter int MAX_HALF = 8,
   parameter int CONFIRM  = 3,
   parameter int CNT_W    = 4
) (
   input  logic                  CLK,
   input  logic                  reset,
   alarm_blink_decoder_if.slave  bus
);
   localparam int GOOD_W = $clog2(CONFIRM + 1);

   localparam logic [CNT_W-1:0]  MIN_V  = CNT_W'(MIN_HALF);
   localparam logic [CNT_W-1:0]  MAX_V  = CNT_W'(MAX_HALF);
   localparam logic [CNT_W-1:0]  SAT_V  = CNT_W'(MAX_HALF + 1);
   localparam logic [CNT_W-1:0]  ONE_V  = CNT_W'(1);
   localparam logic [GOOD_W-1:0] LAST_G = GOOD_W'(CONFIRM - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOCKING = 2'd1,
      ALARM   = 2'd2,
      STUCK   = 2'd3
   } state_t;

   state_t              state;
   logic                s1, s2, s3;
   logic [CNT_W-1:0]    run_cnt;
   logic [GOOD_W-1:0]   good_cnt;

   logic edge_det;
   logic timeout;
   logic valid;

   // run_cnt is checked before it is updated, so a saturated count with no
   // edge this cycle is the idle/stuck timeout.
   assign edge_det = s2 ^ s3;
   assign timeout  = (run_cnt == SAT_V) && !edge_det;
   assign valid    = (run_cnt >= MIN_V) && (run_cnt <= MAX_V);

   always_ff @(posedge CLK) begin
      if (!reset) begin
         s1            <= 1'b0;
         s2            <= 1'b0;
         s3            <= 1'b0;
         run_cnt       <= ONE_V;
         good_cnt      <= '0;
         state         <= IDLE;
         bus.A         <= 1'b0;
         bus.steady_on <= 1'b0;
         bus.err       <= 1'b0;
         bus.half_len  <= '0;
      end else begin
         s1      <= bus.L;
         s2      <= s1;
         s3      <= s2;
         bus.err <= 1'b0;

         if (edge_det) begin
            run_cnt      <= ONE_V;
            bus.half_len <= run_cnt;
         end else if (run_cnt != SAT_V) begin
            run_cnt <= run_cnt + ONE_V;
         end

         case (state)
            IDLE: begin
               // The first edge only starts a measurement; it is never qualified.
               if (edge_det) begin
                  state    <= LOCKING;
                  good_cnt <= '0;
               end else if (timeout && s2) begin
                  state         <= STUCK;
                  bus.steady_on <= 1'b1;
               end
            end
            LOCKING: begin
               if (edge_det) begin
                  if (valid) begin
                     good_cnt <= good_cnt + GOOD_W'(1);
                     if (good_cnt == LAST_G) begin
                        state <= ALARM;
                        bus.A <= 1'b1;
                     end
                  end else begin
                     bus.err  <= 1'b1;
                     good_cnt <= '0;
                  end
               end else if (timeout) begin
                  good_cnt      <= '0;
                  state         <= s2 ? STUCK : IDLE;
                  bus.steady_on <= s2;
               end
            end
            ALARM: begin
               if (edge_det) begin
                  if (!valid) begin
                     bus.err  <= 1'b1;
                     good_cnt <= '0;
                     state    <= LOCKING;
                     bus.A    <= 1'b0;
                  end
               end else if (timeout) begin
                  good_cnt      <= '0;
                  state         <= s2 ? STUCK : IDLE;
                  bus.A         <= 1'b0;
                  bus.steady_on <= s2;
               end
            end
            STUCK: begin
               // The stuck interval is not a half-period, so no err on release.
               if (edge_det) begin
                  state         <= LOCKING;
                  good_cnt      <= '0;
                  bus.steady_on <= 1'b0;
               end
            end
            default: begin
               state         <= IDLE;
               good_cnt      <= '0;
               bus.A         <= 1'b0;
               bus.steady_on <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alarm_blink_decoder.sv
// tb/tb_alarm_blink_decoder.sv - randomized model-checked bench for alarm_blink_decoder
module tb_alarm_blink_decoder;
   localparam int MIN_HALF = 2;
   localparam int MAX_HALF = 8;
   localparam int CONFIRM  = 3;
   localparam int CNT_W    = 4;
   localparam int SAT      = MAX_HALF + 1;

   localparam int P_IDLE  = 0;
   localparam int P_LOCK  = 1;
   localparam int P_ALARM = 2;
   localparam int P_STUCK = 3;

   logic CLK;
   logic reset;

   alarm_blink_decoder_if #(.CNT_W(CNT_W)) bif();

   alarm_blink_decoder #(
      .MIN_HALF(MIN_HALF),
      .MAX_HALF(MAX_HALF),
      .CONFIRM (CONFIRM),
      .CNT_W   (CNT_W)
   ) dut (
      .CLK  (CLK),
      .reset(reset),
      .bus  (bif)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   // Model: L as seen after the two-flop synchronizer, delayed once more for
   // edge detection; the half-period is the cycle distance between edges.
   logic [2:0] dl;
   int  cyc;
   int  last_edge;
   int  ph;
   int  good;
   logic eA, eS, eE;
   int  eH;
   logic cur;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_step(input logic l, input logic r);
      logic seen, prev, edge_now;
      int run;
      cyc++;
      if (!r) begin
         dl        = '0;
         last_edge = cyc;
         ph        = P_IDLE;
         good      = 0;
         eA = 1'b0; eS = 1'b0; eE = 1'b0; eH = 0;
         return;
      end
      seen     = dl[1];
      prev     = dl[2];
      edge_now = (seen != prev);
      run      = cyc - last_edge;
      if (run > SAT) run = SAT;
      dl = {dl[1], dl[0], l};
      eE = 1'b0;
      if (edge_now) begin
         eH        = run;
         last_edge = cyc;
         case (ph)
            P_IDLE:  begin ph = P_LOCK; good = 0; end
            P_LOCK: begin
               if (run >= MIN_HALF && run <= MAX_HALF) begin
                  good++;
                  if (good == CONFIRM) ph = P_ALARM;
               end else begin
                  eE = 1'b1; good = 0;
               end
            end
            P_ALARM: begin
               if (!(run >= MIN_HALF && run <= MAX_HALF)) begin
                  eE = 1'b1; good = 0; ph = P_LOCK;
               end
            end
            default: begin ph = P_LOCK; good = 0; end
         endcase
      end else if (run == SAT) begin
         case (ph)
            P_IDLE:  if (seen) ph = P_STUCK;
            P_LOCK, P_ALARM: begin ph = seen ? P_STUCK : P_IDLE; good = 0; end
            default: ;
         endcase
      end
      eA = (ph == P_ALARM);
      eS = (ph == P_STUCK);
   endtask

   task automatic compare();
      chk("A",         int'(bif.A),         int'(eA));
      chk("steady_on", int'(bif.steady_on), int'(eS));
      chk("err",       int'(bif.err),       int'(eE));
      chk("half_len",  int'(bif.half_len),  eH);
   endtask

   task automatic step(input logic l, input logic r);
      bif.L = l;
      reset = r;
      @(posedge CLK);
      model_step(l, r);
      @(negedge CLK);
      compare();
   endtask

   task automatic half(input logic l, input int n);
      for (int i = 0; i < n; i++) step(l, 1'b1);
   endtask

   task automatic lock();
      for (int i = 0; i < 5; i++) begin
         cur = ~cur;
         half(cur, 4);
      end
   endtask

   initial begin
      dl = '0; cyc = 0; last_edge = 0; ph = P_IDLE; good = 0;
      eA = 1'b0; eS = 1'b0; eE = 1'b0; eH = 0;
      cur   = 1'b0;
      bif.L = 1'b0;
      reset = 1'b0;
      @(negedge CLK);

      // reset held with L toggling
      step(1'b1, 1'b0);
      chk("rst_A", int'(bif.A), 0);
      chk("rst_half_len", int'(bif.half_len), 0);
      step(1'b0, 1'b0);
      chk("rst_steady", int'(bif.steady_on), 0);
      chk("rst_err", int'(bif.err), 0);

      // square wave, half=4; A rises exactly 3 cycles after the 4th transition
      half(1'b0, 3);
      half(1'b1, 4);
      half(1'b0, 4);
      half(1'b1, 4);
      step(1'b0, 1'b1);
      chk("sq_A_t1", int'(bif.A), 0);
      step(1'b0, 1'b1);
      chk("sq_A_t2", int'(bif.A), 0);
      step(1'b0, 1'b1);
      chk("sq_A_t3", int'(bif.A), 1);
      chk("sq_half_len", int'(bif.half_len), 4);
      chk("sq_err", int'(bif.err), 0);
      step(1'b0, 1'b1);
      cur = 1'b0;

      // locked then held low: timeout to idle
      half(1'b1, 4); cur = 1'b1;
      half(1'b0, 20); cur = 1'b0;
      chk("low_A", int'(bif.A), 0);
      chk("low_steady", int'(bif.steady_on), 0);

      // locked then held high: stuck; falling edge releases
      lock();
      chk("lock_A", int'(bif.A), 1);
      if (cur == 1'b1) begin cur = 1'b0; half(cur, 4); end
      cur = 1'b1;
      half(cur, 20);
      chk("stuck_A", int'(bif.A), 0);
      chk("stuck_steady", int'(bif.steady_on), 1);
      cur = 1'b0;
      half(cur, 3);
      chk("unstuck_steady", int'(bif.steady_on), 0);
      chk("unstuck_err", int'(bif.err), 0);
      half(cur, 2);

      // glitch half of length 1
      lock();
      chk("lock2_A", int'(bif.A), 1);
      cur = ~cur; half(cur, 1);
      cur = ~cur;
      half(cur, 2);
      chk("glitch_err_early", int'(bif.err), 0);
      half(cur, 1);
      chk("glitch_err", int'(bif.err), 1);
      chk("glitch_half_len", int'(bif.half_len), 1);
      chk("glitch_A", int'(bif.A), 0);
      half(cur, 1);
      chk("glitch_err_once", int'(bif.err), 0);
      for (int i = 0; i < 4; i++) begin cur = ~cur; half(cur, 4); end
      chk("relock_A", int'(bif.A), 1);

      // over-long half of 9
      cur = ~cur; half(cur, 9);
      cur = ~cur; half(cur, 3);
      chk("long_err", int'(bif.err), 1);
      chk("long_half_len", int'(bif.half_len), 9);
      chk("long_A", int'(bif.A), 0);
      half(cur, 1);

      // reset pulse while locked, mid-half
      lock();
      half(cur, 1);
      step(cur, 1'b0);
      chk("mid_rst_A", int'(bif.A), 0);
      chk("mid_rst_half_len", int'(bif.half_len), 0);
      half(cur, 2);
      for (int i = 0; i < 3; i++) begin cur = ~cur; half(cur, 4); end
      chk("partial_relock_A", int'(bif.A), 0);
      cur = ~cur; half(cur, 4);
      chk("full_relock_A", int'(bif.A), 1);

      // randomized half-periods, long holds and occasional resets
      for (int i = 0; i < 400; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 3) begin
            for (int k = 0; k <= r; k++) step(cur, 1'b0);
         end else begin
            cur = ~cur;
            if (r < 12) half(cur, int'($urandom_range(10, 20)));
            else        half(cur, int'($urandom_range(1, 10)));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
